// File: rtl/sram_xbar_nport.sv
// rtl/sram_xbar_nport.sv - N-port banked SRAM crossbar with per-bank round-robin arbitration
module sram_xbar_nport #(
    parameter int NUM_PORT = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int RD_LAT   = 1,
    localparam int BANK_W  = $clog2(NUM_PORT)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PORT-1:0]                  req_vld,
    input  logic [NUM_PORT-1:0]                  req_wr,
    input  logic [NUM_PORT-1:0][BANK_W-1:0]      req_bank,
    input  logic [NUM_PORT-1:0][ADDR_W-1:0]      req_addr,
    input  logic [NUM_PORT-1:0][DATA_W-1:0]      req_wdata,
    output logic [NUM_PORT-1:0]                  req_rdy,
    output logic [NUM_PORT-1:0]                  rsp_vld,
    output logic [NUM_PORT-1:0][DATA_W-1:0]      rsp_data,
    output logic [15:0]                          conflict_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Per-bank round-robin pointer: first port examined in the next search.
    logic [NUM_PORT-1:0][BANK_W-1:0]   ptr_q;
    // bank_req[b][p]: port p has a valid request aimed at bank b.
    logic [NUM_PORT-1:0][NUM_PORT-1:0] bank_req;
    logic [NUM_PORT-1:0]               gnt_vld;
    logic [NUM_PORT-1:0][BANK_W-1:0]   gnt_idx;
    logic [BANK_W-1:0]                 idx;

    // Command of the port each bank granted this cycle.
    logic [NUM_PORT-1:0]               bank_wr;
    logic [NUM_PORT-1:0][ADDR_W-1:0]   bank_addr;
    logic [NUM_PORT-1:0][DATA_W-1:0]   bank_wdata;

    logic [DATA_W-1:0] mem   [NUM_PORT][DEPTH];
    // Bank read data travels in lockstep with the per-port {valid, bank} pipe.
    logic [DATA_W-1:0] dpipe [NUM_PORT][RD_LAT];
    logic [NUM_PORT-1:0][RD_LAT-1:0] vpipe;
    logic [BANK_W-1:0] bpipe [NUM_PORT][RD_LAT];

    logic conflict;

    // Decode each port's bank id into per-bank request vectors.
    always_comb begin
        bank_req = '0;
        for (int b = 0; b < NUM_PORT; b++) begin
            for (int p = 0; p < NUM_PORT; p++) begin
                bank_req[b][p] = req_vld[p] && (req_bank[p] == BANK_W'(b));
            end
        end
    end

    // Round-robin search upward from each bank pointer; BANK_W-bit add gives the wrap.
    always_comb begin
        gnt_vld = '0;
        gnt_idx = '0;
        idx     = '0;
        for (int b = 0; b < NUM_PORT; b++) begin
            for (int i = 0; i < NUM_PORT; i++) begin
                idx = ptr_q[b] + BANK_W'(i);
                if (!gnt_vld[b] && bank_req[b][idx]) begin
                    gnt_vld[b] = 1'b1;
                    gnt_idx[b] = idx;
                end
            end
        end
    end

    // A port is ready when the bank it targets granted it; address/data play no part.
    always_comb begin
        req_rdy = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            req_rdy[p] = gnt_vld[req_bank[p]] && (gnt_idx[req_bank[p]] == BANK_W'(p));
        end
    end

    // Steer the granted port's command onto each bank.
    always_comb begin
        bank_wr    = '0;
        bank_addr  = '0;
        bank_wdata = '0;
        for (int b = 0; b < NUM_PORT; b++) begin
            bank_wr[b]    = req_wr[gnt_idx[b]];
            bank_addr[b]  = req_addr[gnt_idx[b]];
            bank_wdata[b] = req_wdata[gnt_idx[b]];
        end
    end

    // Bank write port; no access happens while reset is held.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_PORT; b++) begin
            if (rst_n && gnt_vld[b] && bank_wr[b]) begin
                mem[b][bank_addr[b]] <= bank_wdata[b];
            end
        end
    end

    // Bank read data pipeline; contents are qualified by the port valid pipe.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_PORT; b++) begin
            dpipe[b][0] <= mem[b][bank_addr[b]];
            for (int s = 1; s < RD_LAT; s++) begin
                dpipe[b][s] <= dpipe[b][s-1];
            end
        end
    end

    // Per-port return pipeline of {valid, bank id}; reset discards in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
            for (int p = 0; p < NUM_PORT; p++) begin
                for (int s = 0; s < RD_LAT; s++) begin
                    bpipe[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NUM_PORT; p++) begin
                vpipe[p][0] <= req_vld[p] && req_rdy[p] && !req_wr[p];
                bpipe[p][0] <= req_bank[p];
                for (int s = 1; s < RD_LAT; s++) begin
                    vpipe[p][s] <= vpipe[p][s-1];
                    bpipe[p][s] <= bpipe[p][s-1];
                end
            end
        end
    end

    // Return data to the originating port, forced to zero when not valid.
    always_comb begin
        rsp_vld  = '0;
        rsp_data = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            rsp_vld[p] = vpipe[p][RD_LAT-1];
            if (vpipe[p][RD_LAT-1]) begin
                rsp_data[p] = dpipe[bpipe[p][RD_LAT-1]][RD_LAT-1];
            end
        end
    end

    // Pointer moves past the granted port and holds when the bank is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            for (int b = 0; b < NUM_PORT; b++) begin
                if (gnt_vld[b]) begin
                    ptr_q[b] <= gnt_idx[b] + BANK_W'(1);
                end
            end
        end
    end

    assign conflict = |(req_vld & ~req_rdy);

    // Saturating count of cycles in which some valid request had to wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_sram_xbar_nport.sv
// tb/tb_sram_xbar_nport.sv - scoreboard bench for sram_xbar_nport
module tb_sram_xbar_nport;

    localparam int NP  = 4;
    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int BW  = 2;
    localparam int LAT = 3;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NP-1:0]          req_vld;
    logic [NP-1:0]          req_wr;
    logic [NP-1:0][BW-1:0]  req_bank;
    logic [NP-1:0][AW-1:0]  req_addr;
    logic [NP-1:0][DW-1:0]  req_wdata;
    logic [NP-1:0]          req_rdy;
    logic [NP-1:0]          rsp_vld;
    logic [NP-1:0][DW-1:0]  rsp_data;
    logic [15:0]            conflict_cnt;

    sram_xbar_nport #(
        .NUM_PORT (NP),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .RD_LAT   (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_vld      (req_vld),
        .req_wr       (req_wr),
        .req_bank     (req_bank),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rdy      (req_rdy),
        .rsp_vld      (rsp_vld),
        .rsp_data     (rsp_data),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          zero_chk = 1'b1;
    logic [31:0] exp_d [NP];
    int          rsp_cnt [NP] = '{default: 0};
    int          base_cnt [NP];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: match each response to the oldest expectation of its port.
    always @(negedge clk) begin
        int k;
        for (int p = 0; p < NP; p++) begin
            if (rsp_vld[p]) begin
                rsp_cnt[p]++;
                k = -1;
                for (int i = 0; i < sb.size(); i++) begin
                    if (k < 0 && sb[i].port == p) k = i;
                end
                if (k < 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rsp port %0d: got data %0h, no response expected (cycle %0d)",
                             p, rsp_data[p], cyc);
                end else begin
                    chk($sformatf("rsp_data_p%0d", p), rsp_data[p], sb[k].data);
                    chk($sformatf("rsp_cycle_p%0d", p), 32'(cyc), 32'(sb[k].due));
                    sb.delete(k);
                end
            end else if (zero_chk) begin
                chk($sformatf("rsp_zero_p%0d", p), rsp_data[p], 32'h0);
            end
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL missing_rsp port %0d: got nothing, expected %0h at cycle %0d",
                         sb[i].port, sb[i].data, sb[i].due);
                sb.delete(i);
            end
        end
    end

    task automatic idle_all();
        req_vld = '0;
        req_wr  = '0;
    endtask

    task automatic set_req(int p, bit wr, int bank, int addr, logic [31:0] d);
        req_vld[p]   = 1'b1;
        req_wr[p]    = wr;
        req_bank[p]  = BW'(bank);
        req_addr[p]  = AW'(addr);
        req_wdata[p] = d;
    endtask

    // Called at posedge+1 with inputs set; checks grants, records expected reads, advances a cycle.
    task automatic issue(string name, logic [3:0] exp_rdy, bit track);
        exp_t e;
        #1;
        chk(name, 32'(req_rdy), 32'(exp_rdy));
        if (track) begin
            for (int p = 0; p < NP; p++) begin
                if (exp_rdy[p] && req_vld[p] && !req_wr[p]) begin
                    e.port = p;
                    e.data = exp_d[p];
                    e.due  = cyc + LAT;
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        idle_all();
        req_bank  = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int p = 0; p < NP; p++) exp_d[p] = '0;
        @(posedge clk);
        #1;

        // Reset state; arbiter still resolves from reset pointers.
        chk("rst_rsp_vld", 32'(rsp_vld), 32'h0);
        chk("rst_conflict", 32'(conflict_cnt), 32'h0);
        set_req(0, 1'b0, 1, 5, 0);
        set_req(2, 1'b0, 1, 5, 0);
        issue("rst_rdy", 4'b0001, 1'b0);
        chk("rst_conflict_held", 32'(conflict_cnt), 32'h0);
        idle_all();
        rst_n = 1'b1;
        wait_cyc(1);

        // Parallel writes to distinct banks, then parallel reads.
        for (int p = 0; p < NP; p++) set_req(p, 1'b1, p, 5, 32'hA0 + p);
        issue("wr_all_rdy", 4'b1111, 1'b1);
        for (int p = 0; p < NP; p++) begin
            set_req(p, 1'b0, p, 5, 0);
            exp_d[p] = 32'hA0 + p;
        end
        issue("rd_all_rdy", 4'b1111, 1'b1);
        idle_all();
        wait_cyc(LAT + 2);
        chk("par_conflict", 32'(conflict_cnt), 32'h0);

        // Two ports contend for bank 1 right after reset.
        do_reset();
        set_req(0, 1'b0, 1, 5, 0);
        set_req(2, 1'b0, 1, 5, 0);
        exp_d[0] = 32'hA1;
        exp_d[2] = 32'hA1;
        issue("rr_first", 4'b0001, 1'b1);
        req_vld[0] = 1'b0;
        issue("rr_second", 4'b0100, 1'b1);
        idle_all();
        chk("rr_conflict", 32'(conflict_cnt), 32'h1);
        wait_cyc(LAT + 2);

        // Seed bank 3 (ports 0..3 in turn, leaving its pointer at 0), then 8 cycles of contention.
        for (int p = 0; p < NP; p++) begin
            idle_all();
            set_req(p, 1'b1, 3, p, 32'h30 + p);
            issue("b3_wr_rdy", 4'(1 << p), 1'b1);
        end
        idle_all();
        for (int p = 0; p < NP; p++) begin
            set_req(p, 1'b0, 3, p, 0);
            exp_d[p] = 32'h30 + p;
            base_cnt[p] = rsp_cnt[p];
        end
        for (int k = 0; k < 8; k++) issue($sformatf("rot_rdy_%0d", k), 4'(1 << (k % 4)), 1'b1);
        idle_all();
        wait_cyc(LAT + 2);
        chk("rot_conflict", 32'(conflict_cnt), 32'd9);
        for (int p = 0; p < NP; p++) chk($sformatf("rot_rsp_count_p%0d", p), 32'(rsp_cnt[p] - base_cnt[p]), 32'd2);

        // Back-to-back reads on port 1 to bank 0 addresses 0..3.
        for (int a = 0; a < 4; a++) begin
            set_req(1, 1'b1, 0, a, 32'h100 + a);
            issue("b0_wr_rdy", 4'b0010, 1'b1);
        end
        for (int a = 0; a < 4; a++) begin
            set_req(1, 1'b0, 0, a, 0);
            exp_d[1] = 32'h100 + a;
            issue("b2b_rd_rdy", 4'b0010, 1'b1);
        end
        idle_all();
        wait_cyc(LAT + 2);

        // Endless write conflict on bank 2 saturates the counter.
        zero_chk = 1'b0;
        set_req(0, 1'b1, 2, 7, 32'h1);
        set_req(1, 1'b1, 2, 7, 32'h2);
        wait_cyc(70000);
        idle_all();
        zero_chk = 1'b1;
        chk("sat_conflict", 32'(conflict_cnt), 32'hFFFF);

        // Reset one cycle after a read accept discards it and clears pointers.
        do_reset();
        chk("rst2_conflict", 32'(conflict_cnt), 32'h0);
        set_req(0, 1'b0, 0, 1, 0);
        issue("inflight_rdy", 4'b0001, 1'b0);
        idle_all();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(rsp_vld), 32'h0);
        chk("mid_rst_conflict", 32'(conflict_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 3; k++) begin
            wait_cyc(1);
            chk("post_rst_vld", 32'(rsp_vld), 32'h0);
        end
        chk("post_rst_conflict", 32'(conflict_cnt), 32'h0);
        set_req(0, 1'b0, 0, 2, 0);
        set_req(1, 1'b0, 0, 3, 0);
        exp_d[0] = 32'h102;
        exp_d[1] = 32'h103;
        issue("ptr0_first", 4'b0001, 1'b1);
        req_vld[0] = 1'b0;
        issue("ptr0_second", 4'b0010, 1'b1);
        idle_all();
        chk("ptr0_conflict", 32'(conflict_cnt), 32'h1);

        for (int k = 0; k < 50 && sb.size() > 0; k++) wait_cyc(1);
        wait_cyc(2);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
